// File: rtl/multi_spy_buffer.sv
// Multi-channel spy buffer: per-channel flow-control FIFO, circular spy
// memory with end-of-event list, shared freeze FSM and muxed spy readout.
module multi_spy_buffer #(
  parameter int DATA_WIDTH    = 64,
  parameter int CHAN_WIDTH    = 2,
  parameter int SPY_MEM_WIDTH = 7,
  parameter int FC_FIFO_WIDTH = 3,
  parameter int EL_MEM_WIDTH  = 4,
  parameter int AF_MARGIN     = 2,
  localparam int W     = DATA_WIDTH + 1,
  localparam int NCHAN = 2 ** CHAN_WIDTH
) (
  input  logic                             clock,
  input  logic                             reset,
  input  logic [NCHAN*W-1:0]               write_data,
  input  logic [NCHAN-1:0]                 write_enable,
  input  logic [NCHAN-1:0]                 read_enable,
  output logic [NCHAN*W-1:0]               read_data,
  output logic [NCHAN-1:0]                 empty,
  output logic [NCHAN-1:0]                 full,
  output logic [NCHAN-1:0]                 almost_full,
  output logic [NCHAN-1:0]                 overflow,
  input  logic                             freeze,
  input  logic [SPY_MEM_WIDTH-1:0]         post_trigger,
  input  logic                             resume,
  output logic                             frozen,
  input  logic [CHAN_WIDTH-1:0]            spy_chan_sel,
  input  logic                             spy_read_enable,
  input  logic [SPY_MEM_WIDTH-1:0]         spy_read_addr,
  output logic [W-1:0]                     spy_data,
  input  logic                             spy_meta_read_enable,
  input  logic [EL_MEM_WIDTH-1:0]          spy_meta_read_addr,
  output logic [SPY_MEM_WIDTH:0]           spy_meta_read_data,
  output logic [NCHAN*SPY_MEM_WIDTH-1:0]   spy_write_addr,
  output logic [NCHAN*EL_MEM_WIDTH-1:0]    spy_meta_write_addr,
  output logic [NCHAN-1:0]                 spy_wrapped
);

  localparam int FC_D  = 2 ** FC_FIFO_WIDTH;
  localparam int SPY_D = 2 ** SPY_MEM_WIDTH;
  localparam int EL_D  = 2 ** EL_MEM_WIDTH;
  localparam logic [FC_FIFO_WIDTH:0] OCC_FULL =
    (FC_FIFO_WIDTH+1)'(FC_D);
  localparam logic [FC_FIFO_WIDTH:0] OCC_AF =
    (FC_FIFO_WIDTH+1)'(FC_D - AF_MARGIN);

  typedef enum logic [1:0] {RUN, ARMED, FROZEN} state_t;

  state_t                   r_state;
  logic [SPY_MEM_WIDTH-1:0] r_cnt;
  logic                     r_frozen;
  logic                     w_cap;

  logic [W-1:0]             r_fifo [NCHAN][FC_D];
  logic [FC_FIFO_WIDTH-1:0] r_wp [NCHAN];
  logic [FC_FIFO_WIDTH-1:0] r_rp [NCHAN];
  logic [FC_FIFO_WIDTH:0]   r_occ [NCHAN];
  logic [FC_FIFO_WIDTH:0]   w_occ_nxt [NCHAN];
  logic [W-1:0]             w_wd [NCHAN];
  logic [NCHAN-1:0]         r_empty, r_full, r_af, r_ovf, r_wrap;
  logic [NCHAN-1:0]         w_wr, w_rd, w_cap_wr, w_eoe_wr;

  logic [W-1:0]             r_spy [NCHAN][SPY_D];
  logic [SPY_MEM_WIDTH-1:0] r_sp [NCHAN];
  logic [SPY_MEM_WIDTH-1:0] r_el [NCHAN][EL_D];
  logic [EL_D-1:0]          r_el_vld [NCHAN];
  logic [EL_MEM_WIDTH-1:0]  r_mp [NCHAN];

  logic [W-1:0]             r_spy_data;
  logic [SPY_MEM_WIDTH:0]   r_meta_data;

  assign w_cap = (r_state != FROZEN);

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state  <= RUN;
      r_cnt    <= '0;
      r_frozen <= 1'b0;
    end else begin
      unique case (r_state)
        RUN: if (freeze) begin
          if (post_trigger == '0) begin
            r_state  <= FROZEN;
            r_frozen <= 1'b1;
          end else begin
            r_state <= ARMED;
            r_cnt   <= post_trigger;
          end
        end
        // resume aborts the post-trigger window
        ARMED: if (resume) begin
          r_state <= RUN;
        end else begin
          r_cnt <= r_cnt - SPY_MEM_WIDTH'(1);
          if (r_cnt == SPY_MEM_WIDTH'(1)) begin
            r_state  <= FROZEN;
            r_frozen <= 1'b1;
          end
        end
        FROZEN: if (resume) begin
          r_state  <= RUN;
          r_frozen <= 1'b0;
        end
        default: r_state <= RUN;
      endcase
    end
  end

  always_comb begin
    for (int c = 0; c < NCHAN; c++) begin
      w_wd[c]      = write_data[c*W +: W];
      w_wr[c]      = write_enable[c] & ~r_full[c];
      w_rd[c]      = read_enable[c] & ~r_empty[c];
      w_cap_wr[c]  = write_enable[c] & w_cap;
      w_eoe_wr[c]  = w_cap_wr[c] & w_wd[c][DATA_WIDTH];
      w_occ_nxt[c] = r_occ[c]
                   + (FC_FIFO_WIDTH+1)'(w_wr[c])
                   - (FC_FIFO_WIDTH+1)'(w_rd[c]);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_empty <= '1;
      r_full  <= '0;
      r_af    <= '0;
      r_ovf   <= '0;
      r_wrap  <= '0;
      for (int c = 0; c < NCHAN; c++) begin
        r_wp[c]     <= '0;
        r_rp[c]     <= '0;
        r_occ[c]    <= '0;
        r_sp[c]     <= '0;
        r_mp[c]     <= '0;
        r_el_vld[c] <= '0;
      end
    end else begin
      for (int c = 0; c < NCHAN; c++) begin
        if (w_wr[c]) r_wp[c] <= r_wp[c] + FC_FIFO_WIDTH'(1);
        if (w_rd[c]) r_rp[c] <= r_rp[c] + FC_FIFO_WIDTH'(1);
        r_occ[c]   <= w_occ_nxt[c];
        r_empty[c] <= (w_occ_nxt[c] == '0);
        r_full[c]  <= (w_occ_nxt[c] == OCC_FULL);
        r_af[c]    <= (w_occ_nxt[c] >= OCC_AF);
        if (write_enable[c] && r_full[c]) r_ovf[c] <= 1'b1;
        if (w_cap_wr[c]) begin
          r_sp[c] <= r_sp[c] + SPY_MEM_WIDTH'(1);
          if (r_sp[c] == '1) r_wrap[c] <= 1'b1;
        end
        if (w_eoe_wr[c]) begin
          r_el_vld[c][r_mp[c]] <= 1'b1;
          r_mp[c] <= r_mp[c] + EL_MEM_WIDTH'(1);
        end
      end
    end
  end

  // storage arrays carry no reset; writes are suppressed during reset
  always_ff @(posedge clock) begin
    if (!reset) begin
      for (int c = 0; c < NCHAN; c++) begin
        if (w_wr[c])     r_fifo[c][r_wp[c]] <= w_wd[c];
        if (w_cap_wr[c]) r_spy[c][r_sp[c]]  <= w_wd[c];
        if (w_eoe_wr[c]) r_el[c][r_mp[c]]   <= r_sp[c];
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_spy_data  <= '0;
      r_meta_data <= '0;
    end else begin
      if (spy_read_enable)
        r_spy_data <= r_spy[spy_chan_sel][spy_read_addr];
      if (spy_meta_read_enable)
        r_meta_data <= {
          r_el_vld[spy_chan_sel][spy_meta_read_addr],
          r_el[spy_chan_sel][spy_meta_read_addr]};
    end
  end

  always_comb begin
    read_data           = '0;
    spy_write_addr      = '0;
    spy_meta_write_addr = '0;
    for (int c = 0; c < NCHAN; c++) begin
      read_data[c*W +: W] = r_empty[c] ? '0 : r_fifo[c][r_rp[c]];
      spy_write_addr[c*SPY_MEM_WIDTH +: SPY_MEM_WIDTH] = r_sp[c];
      spy_meta_write_addr[c*EL_MEM_WIDTH +: EL_MEM_WIDTH] = r_mp[c];
    end
  end

  assign empty              = r_empty;
  assign full               = r_full;
  assign almost_full        = r_af;
  assign overflow           = r_ovf;
  assign spy_wrapped        = r_wrap;
  assign frozen             = r_frozen;
  assign spy_data           = r_spy_data;
  assign spy_meta_read_data = r_meta_data;

endmodule
